ddr2_cmd_sched: RTL and testbench

DDR2_CMD_SCHED -- requirements
Module: ddr2_cmd_sched

---
 rtl/ddr2_cmd_sched.sv | 218 +++++++++++++++++++++
 tb/tb_ddr2_cmd_sched.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_cmd_sched.sv
// DDR2 command scheduler: per-bank open-row tracking, ACT/PRE/RD/WR sequencing, auto-refresh.
// Latency: row hit issues RD/WR 1 cycle after req_valid; closed/miss paths add T_RCD / T_RP+T_RCD.
// Backpressure: req_ready pulses on the RD/WR issue cycle only; refresh preempts a waiting request.
module ddr2_cmd_sched #(
  parameter int unsigned T_RCD = 3,
  parameter int unsigned T_RP  = 3,
  parameter int unsigned T_RAS = 8,
  parameter int unsigned T_RFC = 26
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_bank,
  input  logic [13:0] req_row,
  input  logic [9:0]  req_col,
  input  logic        refresh_tick,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [2:0]  cmd_bank,
  output logic [13:0] cmd_addr,
  output logic        ref_pending,
  output logic        ref_overrun
);

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_ACT  = 3'd1;
  localparam logic [2:0] C_RD   = 3'd2;
  localparam logic [2:0] C_WR   = 3'd3;
  localparam logic [2:0] C_PRE  = 3'd4;
  localparam logic [2:0] C_PREA = 3'd5;
  localparam logic [2:0] C_REF  = 3'd6;

  // A command is decided one cycle before it reaches the pins, so every
  // counter holds "cycles still to wait before the next decision" and is
  // loaded with T-1. A counter at 0 means the gated command may be registered now.
  localparam logic [7:0] RCD_L = 8'(T_RCD - 1);
  localparam logic [7:0] RP_L  = 8'(T_RP - 1);
  localparam logic [7:0] RAS_L = 8'(T_RAS - 1);
  localparam logic [7:0] RFC_L = 8'(T_RFC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ACT, S_RW, S_PREA, S_REF, S_REF_WAIT
  } state_t;

  state_t      state_q, state_d, eff;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  tras_q [8];
  logic [7:0]  tras_d [8];
  logic [13:0] row_q [8];
  logic [13:0] row_d [8];
  logic [7:0]  open_q, open_d;
  logic        ready_q, ready_d;
  logic        vld_q, vld_d;
  logic [2:0]  code_q, code_d;
  logic [2:0]  bank_q, bank_d;
  logic [13:0] addr_q, addr_d;
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;
  logic        ref_issue;
  logic        ref_req;
  logic        can_decide;
  logic        ras_clear;

  // Refresh request seen this cycle (a tick beats a request sampled alongside it),
  // and whether every open bank has satisfied tRAS so PREA may go out.
  always_comb begin
    ref_req   = pend_q | refresh_tick;
    ras_clear = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (open_q[i] && (tras_q[i] != 8'd0)) ras_clear = 1'b0;
    end
  end

  // Next-state and command decode; IDLE (and an expired REF_WAIT) resolve into
  // their target state within the same cycle so the first command costs no extra cycle.
  always_comb begin
    state_d   = state_q;
    wait_d    = (wait_q != 8'd0) ? wait_q - 8'd1 : 8'd0;
    open_d    = open_q;
    for (int i = 0; i < 8; i++) begin
      tras_d[i] = (tras_q[i] != 8'd0) ? tras_q[i] - 8'd1 : 8'd0;
      row_d[i]  = row_q[i];
    end
    vld_d     = 1'b0;
    code_d    = C_NOP;
    bank_d    = 3'd0;
    addr_d    = 14'd0;
    ready_d   = 1'b0;
    ref_issue = 1'b0;

    // ready_q blocks the still-held request on its own acceptance cycle
    can_decide = (state_q == S_IDLE) || ((state_q == S_REF_WAIT) && (wait_q == 8'd0));
    eff = state_q;
    if (can_decide) begin
      eff = S_IDLE;
      if (ref_req) begin
        eff = (open_q != 8'd0) ? S_PREA : S_REF;
      end else if (req_valid && !ready_q) begin
        if (!open_q[req_bank])                eff = S_ACT;
        else if (row_q[req_bank] == req_row)  eff = S_RW;
        else                                  eff = S_PRE;
      end
    end

    case (eff)
      S_IDLE: state_d = S_IDLE;
      S_PRE: begin
        state_d = S_PRE;
        if (tras_q[req_bank] == 8'd0) begin
          vld_d            = 1'b1;
          code_d           = C_PRE;
          bank_d           = req_bank;
          open_d[req_bank] = 1'b0;
          wait_d           = RP_L;
          state_d          = S_ACT;
        end
      end
      S_ACT: begin
        state_d = S_ACT;
        if (wait_q == 8'd0) begin
          vld_d            = 1'b1;
          code_d           = C_ACT;
          bank_d           = req_bank;
          addr_d           = req_row;
          open_d[req_bank] = 1'b1;
          row_d[req_bank]  = req_row;
          tras_d[req_bank] = RAS_L;
          wait_d           = RCD_L;
          state_d          = S_RW;
        end
      end
      S_RW: begin
        state_d = S_RW;
        if (wait_q == 8'd0) begin
          vld_d   = 1'b1;
          code_d  = req_write ? C_WR : C_RD;
          bank_d  = req_bank;
          addr_d  = {4'b0, req_col};
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_PREA: begin
        state_d = S_PREA;
        if (ras_clear) begin
          vld_d   = 1'b1;
          code_d  = C_PREA;
          addr_d  = 14'h0400;
          open_d  = 8'd0;
          wait_d  = RP_L;
          state_d = S_REF;
        end
      end
      S_REF: begin
        state_d = S_REF;
        if (wait_q == 8'd0) begin
          vld_d     = 1'b1;
          code_d    = C_REF;
          ref_issue = 1'b1;
          wait_d    = RFC_L;
          state_d   = S_REF_WAIT;
        end
      end
      S_REF_WAIT: state_d = S_REF_WAIT;
      default:    state_d = S_IDLE;
    endcase

    // a tick landing on the REF decision cycle starts a fresh refresh, not an overrun
    pend_d = refresh_tick | (pend_q & ~ref_issue);
    ovr_d  = ovr_q | (refresh_tick & pend_q & ~ref_issue);
  end

  // State, bank table, counters and registered command outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
      open_q  <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        tras_q[i] <= 8'd0;
        row_q[i]  <= 14'd0;
      end
      ready_q <= 1'b0;
      vld_q   <= 1'b0;
      code_q  <= C_NOP;
      bank_q  <= 3'd0;
      addr_q  <= 14'd0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      open_q  <= open_d;
      for (int i = 0; i < 8; i++) begin
        tras_q[i] <= tras_d[i];
        row_q[i]  <= row_d[i];
      end
      ready_q <= ready_d;
      vld_q   <= vld_d;
      code_q  <= code_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign req_ready   = ready_q;
  assign cmd_valid   = vld_q;
  assign cmd_code    = code_q;
  assign cmd_bank    = bank_q;
  assign cmd_addr    = addr_q;
  assign ref_pending = pend_q;
  assign ref_overrun = ovr_q;

endmodule

// File: tb/tb_ddr2_cmd_sched.sv
// Bench for ddr2_cmd_sched: schedule-level reference model (absolute issue cycles per command)
// compared every cycle, directed scenarios with literal cycle expectations, then random traffic.
// Model predicts each command's cycle from timing rules; no knowledge of DUT state encoding.
module tb_ddr2_cmd_sched;
  localparam int T_RCD = 3;
  localparam int T_RP  = 3;
  localparam int T_RAS = 8;
  localparam int T_RFC = 26;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_bank = 3'd0;
  logic [13:0] req_row = 14'd0;
  logic [9:0]  req_col = 10'd0;
  logic        refresh_tick = 1'b0;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [2:0]  cmd_bank;
  logic [13:0] cmd_addr;
  logic        ref_pending;
  logic        ref_overrun;

  ddr2_cmd_sched #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_RFC(T_RFC)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .refresh_tick(refresh_tick),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr),
    .ref_pending(ref_pending), .ref_overrun(ref_overrun)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit rand_done = 1'b0;

  typedef struct {
    int          t;
    logic [2:0]  code;
    logic [2:0]  bank;
    logic [13:0] addr;
  } cmd_t;

  cmd_t plan[$];
  cmd_t log_q[$];

  // reference model state: absolute cycle numbers, not counters
  bit          m_open [8];
  logic [13:0] m_row [8];
  int          m_ras [8];
  int          m_free;
  int          m_rw_t;
  int          m_ref_t;
  bit          m_pend;
  bit          m_ovr;

  function automatic cmd_t mk(int t, logic [2:0] c, logic [2:0] b, logic [13:0] a);
    cmd_t r;
    r.t = t; r.code = c; r.bank = b; r.addr = a;
    return r;
  endfunction

  task automatic model_reset();
    plan.delete();
    for (int i = 0; i < 8; i++) begin
      m_open[i] = 1'b0; m_row[i] = 14'd0; m_ras[i] = 0;
    end
    m_free = 0; m_rw_t = -1; m_ref_t = -1; m_pend = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_step(input int c);
    int t;
    bit anyo;
    bit ref_now;
    logic [2:0] b;
    if (c >= m_free) begin
      if (m_pend || refresh_tick) begin
        t = c + 1;
        anyo = 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (m_open[i]) begin
            anyo = 1'b1;
            if (m_ras[i] > t) t = m_ras[i];
          end
        end
        if (anyo) begin
          plan.push_back(mk(t, 3'd5, 3'd0, 14'h0400));
          t = t + T_RP;
        end
        plan.push_back(mk(t, 3'd6, 3'd0, 14'd0));
        m_ref_t = t;
        m_free = t + T_RFC - 1;
        for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
      end else if (req_valid && c != m_rw_t) begin
        t = c + 1;
        b = req_bank;
        if (!(m_open[b] && m_row[b] == req_row)) begin
          if (m_open[b]) begin
            if (m_ras[b] > t) t = m_ras[b];
            plan.push_back(mk(t, 3'd4, b, 14'd0));
            t = t + T_RP;
          end
          plan.push_back(mk(t, 3'd1, b, req_row));
          m_ras[b] = t + T_RAS;
          m_open[b] = 1'b1;
          m_row[b] = req_row;
          t = t + T_RCD;
        end
        plan.push_back(mk(t, req_write ? 3'd3 : 3'd2, b, {4'b0, req_col}));
        m_rw_t = t;
        m_free = t;
      end
    end
    ref_now = (m_ref_t == c + 1);
    m_ovr  = m_ovr | (refresh_tick & m_pend & ~ref_now);
    m_pend = refresh_tick | (m_pend & ~ref_now);
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge ACLK) begin
    cmd_t e;
    bit   e_rdy;
    if (!ARESETN) begin
      tests++;
      if (cmd_valid !== 1'b0 || cmd_code !== 3'd0 || cmd_bank !== 3'd0 || cmd_addr !== 14'd0 ||
          req_ready !== 1'b0 || ref_pending !== 1'b0 || ref_overrun !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs cyc%0d got v%b c%0d b%0d a%h rdy%b pend%b ovr%b want all zero",
                 cyc, cmd_valid, cmd_code, cmd_bank, cmd_addr, req_ready, ref_pending, ref_overrun);
      end
      model_reset();
    end else begin
      e = mk(cyc, 3'd0, 3'd0, 14'd0);
      if (plan.size() != 0 && plan[0].t == cyc) e = plan.pop_front();
      e_rdy = (cyc == m_rw_t);
      tests++;
      if (cmd_valid !== (e.code != 3'd0) || cmd_code !== e.code || cmd_bank !== e.bank ||
          cmd_addr !== e.addr || req_ready !== e_rdy || ref_pending !== m_pend ||
          ref_overrun !== m_ovr) begin
        fails++;
        $display("FAIL cycle_model cyc%0d got v%b c%0d b%0d a%h rdy%b pend%b ovr%b want v%b c%0d b%0d a%h rdy%b pend%b ovr%b",
                 cyc, cmd_valid, cmd_code, cmd_bank, cmd_addr, req_ready, ref_pending, ref_overrun,
                 (e.code != 3'd0), e.code, e.bank, e.addr, e_rdy, m_pend, m_ovr);
      end
      if (cmd_valid) log_q.push_back(mk(cyc, cmd_code, cmd_bank, cmd_addr));
      model_step(cyc);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic first_after(input int from, output int t, output int c, output int b, output int a);
    bit found;
    t = -1; c = -1; b = -1; a = -1;
    found = 1'b0;
    for (int i = 0; i < log_q.size(); i++) begin
      if (!found && log_q[i].t >= from) begin
        found = 1'b1;
        t = log_q[i].t; c = log_q[i].code; b = log_q[i].bank; a = log_q[i].addr;
      end
    end
  endtask

  function automatic int count_code(int from, int to, int code);
    int n;
    n = 0;
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i].t >= from && log_q[i].t <= to && log_q[i].code == code) n++;
    return n;
  endfunction

  // Present a request (optionally with a simultaneous tick), hold until accepted.
  task automatic do_req(input bit w, input logic [2:0] b, input logic [13:0] r, input logic [9:0] c,
                        input bit tk, output int s, output int rc);
    req_valid = 1'b1; req_write = w; req_bank = b; req_row = r; req_col = c;
    if (tk) refresh_tick = 1'b1;
    s = cyc;
    rc = -1;
    for (int n = 0; n < 400 && rc < 0; n++) begin
      @(posedge ACLK); #1;
      if (tk) refresh_tick = 1'b0;
      if (req_ready) rc = cyc;
    end
    if (rc < 0) begin
      tests++; fails++;
      $display("FAIL req_timeout bank%0d row%h got no req_ready want one within 400 cycles", b, r);
    end
    @(posedge ACLK); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not complete, want completion before 900000");
    $fatal(1);
  end

  initial begin
    int s, rc, t, c, b, a, act1, pre_t, a5, p, x;
    model_reset();
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_code", cmd_code, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ref_pending", ref_pending, 0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // read to a closed bank
    do_req(1'b0, 3'd2, 14'h0055, 10'h010, 1'b0, s, rc);
    first_after(s, t, c, b, a);
    chk("rd1_act_cycle", t, s + 1); chk("rd1_act_code", c, 1);
    chk("rd1_act_bank", b, 2);      chk("rd1_act_row", a, 'h55);
    act1 = t;
    first_after(t + 1, t, c, b, a);
    chk("rd1_rd_cycle", t, s + 4);  chk("rd1_rd_code", c, 2); chk("rd1_rd_col", a, 'h10);
    chk("rd1_ready_cycle", rc, s + 4);

    // row hit write
    do_req(1'b1, 3'd2, 14'h0055, 10'h020, 1'b0, s, rc);
    first_after(s, t, c, b, a);
    chk("wr_hit_cycle", t, s + 1); chk("wr_hit_code", c, 3); chk("wr_hit_col", a, 'h20);

    // row miss before tRAS has expired
    do_req(1'b0, 3'd2, 14'h0100, 10'h030, 1'b0, s, rc);
    first_after(s, t, c, b, a);
    chk("miss_pre_code", c, 4); chk("miss_pre_cycle", t, act1 + 8); chk("miss_pre_bank", b, 2);
    pre_t = t;
    first_after(pre_t + 1, t, c, b, a);
    chk("miss_act_cycle", t, pre_t + 3); chk("miss_act_code", c, 1); chk("miss_act_row", a, 'h100);
    first_after(t + 1, t, c, b, a);
    chk("miss_rd_cycle", t, pre_t + 6); chk("miss_rd_code", c, 2);
    chk("miss_ready_cycle", rc, pre_t + 6);

    // banks 0 and 5 open; tick and request in the same cycle
    do_req(1'b0, 3'd0, 14'h0001, 10'h000, 1'b0, s, rc);
    do_req(1'b0, 3'd5, 14'h0002, 10'h000, 1'b0, s, rc);
    first_after(s, a5, c, b, a);
    chk("b5_act_cycle", a5, s + 1);
    do_req(1'b0, 3'd0, 14'h0001, 10'h005, 1'b1, s, rc);
    first_after(s, t, c, b, a);
    chk("prea_code", c, 5); chk("prea_addr", a, 'h400); chk("prea_cycle", t, a5 + 8);
    p = t;
    first_after(p + 1, t, c, b, a);
    chk("ref_code", c, 6); chk("ref_cycle", t, p + 3);
    first_after(t + 1, t, c, b, a);
    chk("post_ref_act_code", c, 1); chk("post_ref_act_cycle", t, p + 3 + 26);
    first_after(t + 1, t, c, b, a);
    chk("post_ref_rd_code", c, 2); chk("post_ref_rd_cycle", t, p + 3 + 29);

    // two ticks before the refresh issues
    x = cyc;
    refresh_tick = 1'b1; @(posedge ACLK); #1;
    refresh_tick = 1'b0; @(posedge ACLK); #1;
    refresh_tick = 1'b1; @(posedge ACLK); #1;
    refresh_tick = 1'b0;
    repeat (60) begin @(posedge ACLK); #1; end
    chk("ovr_single_ref", count_code(x, cyc, 6), 1);
    chk("ovr_flag", ref_overrun, 1);
    chk("ovr_pending_clear", ref_pending, 0);

    // random traffic with random refresh ticks
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) begin @(posedge ACLK); #1; end
          do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 14'($urandom_range(0, 2)),
                 10'($urandom_range(0, 1023)), 1'b0, s, rc);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge ACLK); #1;
          refresh_tick = ($urandom_range(0, 39) == 0);
        end
        refresh_tick = 1'b0;
      end
    join
    repeat (100) begin @(posedge ACLK); #1; end

    // reset between ACT and RD
    req_valid = 1'b1; req_write = 1'b0; req_bank = 3'd6; req_row = 14'h0007; req_col = 10'h003;
    s = cyc;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("arst_cmd_valid", cmd_valid, 0);
    chk("arst_cmd_code", cmd_code, 0);
    chk("arst_ref_overrun", ref_overrun, 0);
    chk("arst_req_ready", req_ready, 0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    repeat (6) begin @(posedge ACLK); #1; end
    chk("arst_act_seen", count_code(s, cyc, 1), 1);
    chk("arst_no_rd", count_code(s, cyc, 2), 0);
    do_req(1'b0, 3'd6, 14'h0007, 10'h003, 1'b0, s, rc);
    first_after(s, t, c, b, a);
    chk("arst_reopen_act", c, 1); chk("arst_reopen_cycle", t, s + 1);

    repeat (5) begin @(posedge ACLK); #1; end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
